// File: rtl/rip_fetch.sv
// rip_fetch: instruction-fetch stage. Keeps one imem request in flight, parks one
// instruction in a skid buffer while execute stalls, and flushes/refetches on redirect.
module rip_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_code,
    output logic [31:0] if_pc,
    output logic        de_ready
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] RESET_ADDR = RESET_PC & ALIGN_MASK;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            outstanding_q, outstanding_d;
    logic            drop_q, drop_d;
    logic            hold_valid_q, hold_valid_d;
    logic [ILEN-1:0] hold_inst_q, hold_inst_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;

    logic [XLEN-1:0] redirect_tgt;
    logic            redirect_act;
    logic            rsp;
    logic            rsp_retire;
    logic            capture;
    logic            hold_next_busy;
    logic            grant;

    // Response acceptance, decode handshake and skid-buffer occupancy for next cycle.
    always_comb begin
        redirect_tgt = redirect_pc & ALIGN_MASK;
        redirect_act = redirect & rst_n;
        rsp_retire   = imem_rvalid & outstanding_q;
        rsp          = rsp_retire & ~drop_q;
        de_ready     = (hold_valid_q | rsp) & ~ex_stall & ~redirect;
        capture      = rsp & (ex_stall | hold_valid_q) & ~redirect;

        hold_valid_d = hold_valid_q;
        if (redirect) begin
            hold_valid_d = 1'b0;
        end else if (de_ready) begin
            hold_valid_d = 1'b0;
        end else if (capture) begin
            hold_valid_d = 1'b1;
        end
        hold_next_busy = hold_valid_d;
    end

    // Request issue: a new request may go out in the same cycle the previous one retires.
    always_comb begin
        imem_req  = rst_n
                  & ~hold_next_busy
                  & (~outstanding_q | imem_rvalid)
                  & ~(drop_q & ~imem_rvalid);
        imem_addr = redirect_act ? redirect_tgt : pc_q;
        grant     = imem_req & imem_gnt;
    end

    // Decode-side output mux: the held entry always wins over a live response.
    always_comb begin
        inst_code = '0;
        if_pc     = '0;
        if (hold_valid_q) begin
            inst_code = hold_inst_q;
            if_pc     = hold_pc_q;
        end else if (rsp) begin
            inst_code = imem_rdata;
            if_pc     = req_pc_q;
        end
    end

    // Next-state for fetch pointer, outstanding tracking and skid payload.
    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        hold_inst_d   = hold_inst_q;
        hold_pc_d     = hold_pc_q;
        req_pc_d      = req_pc_q;

        if (rsp_retire) begin
            outstanding_d = 1'b0;
            drop_d        = 1'b0;
        end

        // A redirect with the response still in flight marks that response stale.
        if (redirect && outstanding_q && !imem_rvalid) begin
            drop_d = 1'b1;
        end

        if (capture) begin
            hold_inst_d = imem_rdata;
            hold_pc_d   = req_pc_q;
        end

        if (grant) begin
            outstanding_d = 1'b1;
            req_pc_d      = imem_addr;
            pc_d          = imem_addr + PC_STEP;
        end else if (redirect) begin
            pc_d = redirect_tgt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_ADDR;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            hold_valid_q  <= 1'b0;
            hold_inst_q   <= '0;
            hold_pc_q     <= '0;
            req_pc_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            hold_valid_q  <= hold_valid_d;
            hold_inst_q   <= hold_inst_d;
            hold_pc_q     <= hold_pc_d;
            req_pc_q      <= req_pc_d;
        end
    end

endmodule

// File: tb/tb_rip_fetch.sv
// tb_rip_fetch: directed scenarios plus randomized traffic for rip_fetch, checked
// against a program-order model (sequential PCs, reset by redirects) and a memory model.
module tb_rip_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk, rst_n, ex_stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_gnt, imem_rvalid, de_ready;
    logic [31:0] imem_addr, imem_rdata, inst_code, if_pc;

    rip_fetch #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_stall   (ex_stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .inst_code  (inst_code),
        .if_pc      (if_pc),
        .de_ready   (de_ready)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t pend_q[$];
    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    int    lat = 1;
    int    gnt_pct = 100;
    bit    gnt_rand = 0;
    bit    gnt_force = 1;
    bit    lat_rand = 0;

    logic        o_req, o_de, o_rv, o_gnt;
    logic [31:0] o_addr, o_inst, o_pc;
    int          o_pend;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        if (a == 32'h8) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // One bus cycle: drive inputs at negedge, let the comb settle, sample, update memory model.
    task automatic drive_cycle(input logic st, input logic rd, input logic [31:0] rp);
        pend_t p;
        @(negedge clk);
        ex_stall    = st;
        redirect    = rd;
        redirect_pc = rp;
        imem_gnt    = gnt_rand ? logic'($urandom_range(0, 99) < gnt_pct) : gnt_force;
        o_pend      = pend_q.size();
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_q[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        o_req  = imem_req;
        o_addr = imem_addr;
        o_de   = de_ready;
        o_inst = inst_code;
        o_pc   = if_pc;
        o_rv   = imem_rvalid;
        o_gnt  = imem_gnt;
        if (imem_rvalid) void'(pend_q.pop_front());
        if (imem_req && imem_gnt) begin
            p.addr = imem_addr;
            p.due  = cyc + (lat_rand ? int'($urandom_range(1, 3)) : lat);
            pend_q.push_back(p);
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ex_stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        pend_q.delete();
        gnt_rand = 0; gnt_force = 1; lat_rand = 0; lat = 1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ex_stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        total++;
        if ({imem_req, de_ready, inst_code, if_pc, imem_addr} !== {1'b0, 1'b0, 32'h0, 32'h0, RST_PC}) begin
            bad++;
            $display("FAIL reset_outputs got req=%0b de=%0b inst=%h pc=%h addr=%h exp 0 0 0 0 %h",
                     imem_req, de_ready, inst_code, if_pc, imem_addr, RST_PC);
        end
        imem_rvalid = 1'b0; imem_gnt = 1'b0;
        pend_q.delete();
        gnt_rand = 0; gnt_force = 1; lat_rand = 0; lat = 1;
        @(posedge clk);
        #2 rst_n = 1'b1;
        drive_cycle(1'b0, 1'b0, 32'h0);
        total++;
        if ({o_req, o_addr, o_de} !== {1'b1, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_first_req got req=%0b addr=%h de=%0b exp 1 0 0", o_req, o_addr, o_de);
        end
        drive_cycle(1'b0, 1'b0, 32'h0);
        total++;
        if ({o_de, o_inst, o_pc, o_addr} !== {1'b1, 32'h0000_0013, 32'h0, 32'h4}) begin
            bad++;
            $display("FAIL reset_first_rsp got de=%0b inst=%h pc=%h addr=%h exp 1 00000013 0 4",
                     o_de, o_inst, o_pc, o_addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset();
        drive_cycle(1'b0, 1'b0, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            drive_cycle(1'b0, 1'b0, 32'h0);
            exp_pc = 32'((i - 1) * 4);
            total++;
            if ({o_de, o_pc, o_inst, o_req, o_addr} !== {1'b1, exp_pc, mem_word(exp_pc), 1'b1, 32'(i * 4)}) begin
                bad++;
                $display("FAIL stream_%0d got de=%0b pc=%h inst=%h req=%0b addr=%h exp pc=%h addr=%h",
                         i, o_de, o_pc, o_inst, o_req, o_addr, exp_pc, 32'(i * 4));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (3) drive_cycle(1'b0, 1'b0, 32'h0);
        drive_cycle(1'b1, 1'b0, 32'h0);
        total++;
        if ({o_de, o_req} !== 2'b00) begin
            bad++;
            $display("FAIL stall_capture got de=%0b req=%0b exp 0 0", o_de, o_req);
        end
        drive_cycle(1'b1, 1'b0, 32'h0);
        total++;
        if ({o_de, o_req} !== 2'b00) begin
            bad++;
            $display("FAIL stall_hold got de=%0b req=%0b exp 0 0", o_de, o_req);
        end
        drive_cycle(1'b0, 1'b0, 32'h0);
        total++;
        if ({o_de, o_inst, o_pc, o_req, o_addr} !== {1'b1, 32'h0050_0093, 32'h8, 1'b1, 32'hC}) begin
            bad++;
            $display("FAIL stall_release got de=%0b inst=%h pc=%h req=%0b addr=%h exp 1 00500093 8 1 c",
                     o_de, o_inst, o_pc, o_req, o_addr);
        end
        drive_cycle(1'b0, 1'b0, 32'h0);
        total++;
        if ({o_de, o_pc} !== {1'b1, 32'hC}) begin
            bad++;
            $display("FAIL stall_resume got de=%0b pc=%h exp 1 c", o_de, o_pc);
        end
    endtask

    task automatic test_redirect_pending();
        do_reset();
        repeat (2) drive_cycle(1'b0, 1'b0, 32'h0);
        lat = 2;
        drive_cycle(1'b0, 1'b0, 32'h0);
        drive_cycle(1'b0, 1'b1, 32'h100);
        total++;
        if ({o_req, o_de} !== 2'b00) begin
            bad++;
            $display("FAIL redir_pend_cycle got req=%0b de=%0b exp 0 0", o_req, o_de);
        end
        lat = 1;
        drive_cycle(1'b0, 1'b0, 32'h0);
        total++;
        if ({o_rv, o_de, o_inst, o_req, o_addr} !== {1'b1, 1'b0, 32'h0, 1'b1, 32'h100}) begin
            bad++;
            $display("FAIL redir_stale_drop got rv=%0b de=%0b inst=%h req=%0b addr=%h exp 1 0 0 1 100",
                     o_rv, o_de, o_inst, o_req, o_addr);
        end
        drive_cycle(1'b0, 1'b0, 32'h0);
        total++;
        if ({o_de, o_pc, o_inst} !== {1'b1, 32'h100, mem_word(32'h100)}) begin
            bad++;
            $display("FAIL redir_target_rsp got de=%0b pc=%h inst=%h exp 1 100 %h",
                     o_de, o_pc, o_inst, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_same_cycle();
        do_reset();
        drive_cycle(1'b0, 1'b0, 32'h0);
        drive_cycle(1'b0, 1'b1, 32'h102);
        total++;
        if ({o_rv, o_de, o_req, o_addr} !== {1'b1, 1'b0, 1'b1, 32'h100}) begin
            bad++;
            $display("FAIL redir_same got rv=%0b de=%0b req=%0b addr=%h exp 1 0 1 100",
                     o_rv, o_de, o_req, o_addr);
        end
        drive_cycle(1'b0, 1'b0, 32'h0);
        total++;
        if ({o_de, o_pc, o_inst, o_addr} !== {1'b1, 32'h100, mem_word(32'h100), 32'h104}) begin
            bad++;
            $display("FAIL redir_same_next got de=%0b pc=%h inst=%h addr=%h exp 1 100 %h 104",
                     o_de, o_pc, o_inst, o_addr, mem_word(32'h100));
        end
    endtask

    task automatic test_gnt_backpressure();
        do_reset();
        gnt_force = 0;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b0, 32'h0);
            total++;
            if ({o_req, o_addr, o_de} !== {1'b1, 32'h0, 1'b0}) begin
                bad++;
                $display("FAIL gnt_wait_%0d got req=%0b addr=%h de=%0b exp 1 0 0", i, o_req, o_addr, o_de);
            end
        end
        gnt_force = 1;
        drive_cycle(1'b0, 1'b0, 32'h0);
        drive_cycle(1'b0, 1'b0, 32'h0);
        total++;
        if ({o_de, o_pc, o_addr} !== {1'b1, 32'h0, 32'h4}) begin
            bad++;
            $display("FAIL gnt_after got de=%0b pc=%h addr=%h exp 1 0 4", o_de, o_pc, o_addr);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        repeat (4) drive_cycle(1'b0, 1'b0, 32'h0);
        total++;
        if (o_de !== 1'b1) begin
            bad++;
            $display("FAIL midrst_pre got de=%0b exp 1", o_de);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({imem_req, de_ready, inst_code, if_pc, imem_addr} !== {1'b0, 1'b0, 32'h0, 32'h0, RST_PC}) begin
            bad++;
            $display("FAIL midrst_async got req=%0b de=%0b inst=%h pc=%h addr=%h exp 0 0 0 0 %h",
                     imem_req, de_ready, inst_code, if_pc, imem_addr, RST_PC);
        end
        imem_rvalid = 1'b0;
        pend_q.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        drive_cycle(1'b0, 1'b0, 32'h0);
        total++;
        if ({o_req, o_addr, o_de} !== {1'b1, RST_PC, 1'b0}) begin
            bad++;
            $display("FAIL midrst_restart got req=%0b addr=%h de=%0b exp 1 %h 0", o_req, o_addr, o_de, RST_PC);
        end
        drive_cycle(1'b0, 1'b0, 32'h0);
        total++;
        if ({o_de, o_pc, o_inst} !== {1'b1, RST_PC, mem_word(RST_PC)}) begin
            bad++;
            $display("FAIL midrst_first got de=%0b pc=%h inst=%h exp 1 %h", o_de, o_pc, o_inst, RST_PC);
        end
    endtask

    // Random traffic: deliveries must follow program order (PC+4, restarted by every redirect).
    task automatic test_random();
        logic [31:0] exp_pc, exp_fetch, rp, tgt, prev_addr;
        logic        st, rd, prev_pend;
        int          n_deliv, n_drain;
        do_reset();
        gnt_rand = 1; gnt_pct = 70; lat_rand = 1;
        exp_pc = RST_PC; exp_fetch = RST_PC;
        prev_pend = 1'b0; prev_addr = '0;
        n_deliv = 0; n_drain = 0;
        for (int k = 0; k < 460; k++) begin
            if (k >= 440) begin
                gnt_rand = 0; gnt_force = 1; lat_rand = 0; lat = 1;
                st = 1'b0; rd = 1'b0; rp = '0;
            end else begin
                st = logic'($urandom_range(0, 99) < 30);
                rd = logic'($urandom_range(0, 99) < 6);
                rp = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 3)))
                                                 : ($urandom & 32'h0000_FFFF);
            end
            drive_cycle(st, rd, rp);
            tgt = rp & 32'hFFFF_FFFC;
            if (rd) begin
                exp_pc    = tgt;
                exp_fetch = tgt;
            end
            if (o_de) begin
                total++;
                if (st || rd || o_pc !== exp_pc || o_inst !== mem_word(exp_pc)) begin
                    bad++;
                    $display("FAIL rand_deliver k=%0d got pc=%h inst=%h st=%0b rd=%0b exp pc=%h inst=%h",
                             k, o_pc, o_inst, st, rd, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'h4;
                n_deliv++;
                if (k >= 440) n_drain++;
            end
            if (o_req) begin
                total++;
                if (o_addr[1:0] !== 2'b00 || (o_pend > 0 && !o_rv)) begin
                    bad++;
                    $display("FAIL rand_req k=%0d got addr=%h pend=%0d rv=%0b exp aligned single outstanding",
                             k, o_addr, o_pend, o_rv);
                end
            end
            if (o_req && o_gnt) begin
                total++;
                if (o_addr !== exp_fetch) begin
                    bad++;
                    $display("FAIL rand_fetch_addr k=%0d got %h exp %h", k, o_addr, exp_fetch);
                end
                exp_fetch = exp_fetch + 32'h4;
            end
            if (prev_pend && !rd) begin
                total++;
                if (!o_req || o_addr !== prev_addr) begin
                    bad++;
                    $display("FAIL rand_stable k=%0d got req=%0b addr=%h exp 1 %h", k, o_req, o_addr, prev_addr);
                end
            end
            prev_pend = o_req && !o_gnt;
            prev_addr = o_addr;
        end
        total++;
        if (n_deliv < 20 || n_drain < 6) begin
            bad++;
            $display("FAIL rand_progress got deliv=%0d drain=%0d exp >=20 >=6", n_deliv, n_drain);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ex_stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_pending();
        test_redirect_same_cycle();
        test_gnt_backpressure();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rip_fetch.md
Name: rip_fetch

Overview:
- Instruction-fetch stage. It drives the instruction-memory request port and delivers fetched instruction words plus their PC to the decode stage.
- It is the producer side of the decode interface: it supplies `inst_code` and asserts `de_ready` only when decode may latch.
- It honours `ex_stall`, buffers one instruction while the pipeline is stalled, and redirects on taken branches, jumps and traps from execute, discarding stale responses.

Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset; bits [1:0] must be 0.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- ex_stall  input  1  execute stalled; decode holds its registers.
- redirect  input  1  taken branch/jump/trap from execute; flush and refetch.
- redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 0).
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch word address; bits [1:0] always 0.
- imem_gnt  input  1  request accepted this cycle when imem_req=1.
- imem_rvalid  input  1  read data valid. In-order; at least 1 cycle after grant; at most one response per grant.
- imem_rdata  input  32  instruction word.
- inst_code  output  32  instruction to decode.
- if_pc  output  32  PC of inst_code.
- de_ready  output  1  decode latches inst_code/if_pc this cycle.

Behaviour:
- State registers:
  - pc: next fetch address.
  - outstanding: one granted, unanswered request.
  - drop: the outstanding response is stale.
  - hold_valid, hold_inst, hold_pc: one-entry skid buffer.
  - req_pc: PC of the outstanding request.
- Asynchronous reset, active immediately:
  - pc=RESET_PC; outstanding=drop=hold_valid=0; hold_inst=hold_pc=req_pc=0.
  - Outputs: imem_req=0, de_ready=0, inst_code=0, if_pc=0, imem_addr=RESET_PC.
- At most one request outstanding.
- Accepted response: rsp = imem_rvalid & outstanding & !drop. imem_rvalid while drop=1 is consumed and discarded, clearing outstanding and drop.
- Output mux (combinational):
  - hold_valid=1: inst_code=hold_inst, if_pc=hold_pc.
  - Otherwise: inst_code=imem_rdata, if_pc=req_pc.
  - inst_code=0 and if_pc=0 when neither a held entry nor rsp is present.
- de_ready = (hold_valid | rsp) & !ex_stall & !redirect.
- Skid buffer:
  - rsp & (ex_stall | hold_valid) & !redirect: capture into hold. This cannot coincide with hold_valid=1 because no request is issued while holding.
  - hold_valid clears when de_ready, or on redirect.
- Request issue:
  - imem_req = !hold_next_busy & (!outstanding | imem_rvalid) & !(drop & !imem_rvalid).
  - hold_next_busy means a valid entry will still be held next cycle.
  - imem_addr = redirect ? {redirect_pc[31:2],2'b00} : pc.
  - imem_req=1 & imem_gnt=0: imem_addr and imem_req stay stable next cycle unless redirect occurs, in which case the new address takes effect.
  - On grant: outstanding=1, req_pc=imem_addr, pc=imem_addr+4 (wraps modulo 2^32).
- Redirect, which has priority over everything:
  - hold_valid cleared; de_ready=0 this cycle.
  - Outstanding request with no response this cycle: drop=1, imem_req=0 until the stale response returns; pc={redirect_pc[31:2],2'b00}.
  - No outstanding request, or its response arriving this cycle: that response is discarded; imem_req=1 with imem_addr = redirect target this cycle.
- Throughput: zero-stall memory (gnt=1, rvalid next cycle) gives one de_ready per cycle after a 1-cycle initial latency.
- ex_stall asserted with no data: no state change other than normal issue.
- Reset asserted mid-transaction: all state cleared. The memory response to the pre-reset request is the memory's responsibility and is not expected after reset.

Test Plan:
- Reset release, RESET_PC=0, gnt=1:
  - Cycle 0: imem_req=1, imem_addr=0x0.
  - Cycle 1: rvalid with rdata 0x00000013 → inst_code=0x00000013, if_pc=0x0, de_ready=1, imem_addr=0x4.
- Streaming, zero-wait memory for 8 cycles → addresses 0x0,0x4,…,0x1C. de_ready=1 every cycle from cycle 1, if_pc tracking in order.
- ex_stall=1 while rdata=0x00500093 (pc 0x8) arrives:
  - de_ready=0, entry held, imem_req=0.
  - ex_stall drops: de_ready=1, inst_code=0x00500093, if_pc=0x8; next request resumes at 0xC.
- redirect=1, redirect_pc=0x100, response for 0x8 still pending:
  - imem_req=0; the later rvalid for 0x8 yields no de_ready.
  - Next cycle: imem_req=1, imem_addr=0x100; its response → if_pc=0x100.
- redirect with redirect_pc=0x102 in the same cycle as a valid response:
  - de_ready=0, response discarded.
  - Same cycle: imem_req=1, imem_addr=0x100.
- imem_gnt=0 for 3 cycles → imem_addr stays stable, pc not incremented. rst_n pulsed low mid-stream → imem_req, de_ready, inst_code drop to 0 asynchronously; fetch restarts at RESET_PC.
